// File: rtl/alu_issue_queue.sv
// alu_issue_queue
//   Issue stage in front of the combinational ALU. Incoming ops (ctrl, a, b) are
//   buffered in a DEPTH-entry FIFO that sits behind a single output register. The
//   output register drives the ALU directly, and a valid/ready handshake retires
//   the op it holds. When the FIFO is empty, an accepted op bypasses the FIFO and
//   loads the output register directly, so it reaches alu_valid one cycle later.
//
//   Optional feature, macro ALU_ISSUE_FWD_EN:
//     An op carrying in_fwd=1 takes operand a from the previous ALU result
//     instead of in_a. If another op retires in the same cycle, alu_res is used;
//     otherwise the last retired result (last_res) is used.
//     When the macro is undefined, in_fwd and alu_res are ignored.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   producer handshake (in_ready = FIFO not full)
//   in_ctrl/in_a/in_b   op to enqueue; ctrl==15 is dropped and flags illegal
//   in_fwd              forward previous result as operand a (FWD build)
//   alu_valid/alu_ready consumer handshake on the output register
//   alu_ctrl/alu_a/alu_b registered op presented to the ALU
//   alu_res             ALU result for the op currently on alu_*
//   count               FIFO occupancy, not counting the output register
//   illegal             sticky flag: an op with ctrl==15 was offered

module alu_issue_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_ctrl,
  input  logic [W-1:0]             in_a,
  input  logic [W-1:0]             in_b,
  input  logic                     in_fwd,
  output logic                     alu_valid,
  input  logic                     alu_ready,
  output logic [3:0]               alu_ctrl,
  output logic [W-1:0]             alu_a,
  output logic [W-1:0]             alu_b,
  input  logic [W-1:0]             alu_res,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [3:0] CTRL_ILLEGAL = 4'hF;

  logic [3:0]   mem_ctrl [DEPTH];
  logic [W-1:0] mem_a    [DEPTH];
  logic [W-1:0] mem_b    [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic accept;
  logic store_ok;
  logic issue;
  logic load_slot;
  logic fifo_empty;
  logic pop;
  logic bypass;
  logic push;

  logic [3:0]   src_ctrl;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;

  assign in_ready   = (count != FULL);
  assign accept     = in_valid && in_ready;
  assign store_ok   = accept && (in_ctrl != CTRL_ILLEGAL);
  assign issue      = alu_valid && alu_ready;
  assign load_slot  = !alu_valid || issue;
  assign fifo_empty = (count == '0);
  assign pop        = load_slot && !fifo_empty;
  // Bypass only when the FIFO is empty, so older queued ops always go first.
  assign bypass     = load_slot && fifo_empty && store_ok;
  assign push       = store_ok && !bypass;

`ifdef ALU_ISSUE_FWD_EN
  logic         mem_fwd [DEPTH];
  logic [W-1:0] last_res;
  logic         src_fwd;
  logic [W-1:0] raw_a;

  always_comb begin
    src_ctrl = in_ctrl;
    raw_a    = in_a;
    src_b    = in_b;
    src_fwd  = in_fwd;
    if (pop) begin
      src_ctrl = mem_ctrl[rd_ptr];
      raw_a    = mem_a[rd_ptr];
      src_b    = mem_b[rd_ptr];
      src_fwd  = mem_fwd[rd_ptr];
    end
    // last_res has not yet captured a result that retires this cycle, so take
    // it straight from the ALU in that case.
    src_a = raw_a;
    if (src_fwd) begin
      src_a = issue ? alu_res : last_res;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_fwd[wr_ptr] <= in_fwd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_res <= '0;
    end else if (issue) begin
      last_res <= alu_res;
    end
  end
`else
  logic unused_sig;
  assign unused_sig = ^{in_fwd, alu_res};

  always_comb begin
    src_ctrl = in_ctrl;
    src_a    = in_a;
    src_b    = in_b;
    if (pop) begin
      src_ctrl = mem_ctrl[rd_ptr];
      src_a    = mem_a[rd_ptr];
      src_b    = mem_b[rd_ptr];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem_ctrl[wr_ptr] <= in_ctrl;
      mem_a[wr_ptr]    <= in_a;
      mem_b[wr_ptr]    <= in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      alu_valid <= 1'b0;
      alu_ctrl  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      illegal   <= 1'b0;
    end else begin
      if (accept && (in_ctrl == CTRL_ILLEGAL)) begin
        illegal <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      // Output register holds steady while stalled; refills when empty or retiring.
      if (load_slot) begin
        alu_valid <= pop || bypass;
        if (pop || bypass) begin
          alu_ctrl <= src_ctrl;
          alu_a    <= src_a;
          alu_b    <= src_b;
        end
      end
    end
  end

endmodule
